tap_dtm_sequencer: RTL and testbench

// - JTAG debug transport behind tap_controller: instruction register, DR chain select/mux, TDO driver.
// - Turns DMI DR updates into a request/response handshake with the debug module.
// - Uses the TAP strobes (capture/shift/update IR/DR) as qualifiers; runs entirely in the tck domain.

---
 rtl/tap_dtm_sequencer_pkg.sv | 34 +++
 rtl/tap_dtm_sequencer_if.sv | 24 ++
 rtl/tap_dtm_sequencer_dmi_fsm.sv | 97 +++++++++
 rtl/tap_dtm_sequencer.sv | 144 ++++++++++++++
 tb/tb_tap_dtm_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_dtm_sequencer_pkg.sv
// Shared constants for the JTAG debug transport: IR opcodes, DMI op codes,
// DMI FSM state encodings, DR chain selectors and DTMCS control bit offsets.
package tap_dtm_sequencer_pkg;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_t;

    typedef logic [1:0] dmi_fsm_t;
    localparam dmi_fsm_t FSM_IDLE = 2'd0;
    localparam dmi_fsm_t FSM_REQ  = 2'd1;
    localparam dmi_fsm_t FSM_WAIT = 2'd2;

    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;

    localparam logic [1:0] CH_IDCODE = 2'd0;
    localparam logic [1:0] CH_DTMCS  = 2'd1;
    localparam logic [1:0] CH_DMI    = 2'd2;
    localparam logic [1:0] CH_BYPASS = 2'd3;

    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;

endpackage

// File: rtl/tap_dtm_sequencer_if.sv
// DMI request/response bundle between the debug transport (master)
// and the debug module (slave).
interface tap_dtm_sequencer_if #(
    parameter int ABITS = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_op;

    modport master (
        output req_valid, req_addr, req_data, req_op,
        input  req_ready, rsp_valid, rsp_data, rsp_op
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op,
        output req_ready, rsp_valid, rsp_data, rsp_op
    );
endinterface

// File: rtl/tap_dtm_sequencer_dmi_fsm.sv
// DMI handshake engine: turns accepted DMI updates into one request/response
// transaction and keeps the sticky busy/failed flags reported on capture.
module tap_dtm_sequencer_dmi_fsm
    import tap_dtm_sequencer_pkg::*;
#(
    parameter int ABITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmi_update,
    input  logic [ABITS-1:0] upd_addr,
    input  logic [31:0]      upd_data,
    input  logic [1:0]       upd_op,
    input  logic             clear_sticky,
    input  logic             hard_reset,
    tap_dtm_sequencer_if.master dmi,
    output logic [ABITS-1:0] last_addr,
    output logic [31:0]      rsp_data,
    output logic [1:0]       status
);

    dmi_fsm_t         state;
    logic             sticky_busy;
    logic             sticky_failed;
    logic [ABITS-1:0] addr_q;
    logic [31:0]      data_q;
    logic [1:0]       op_q;
    logic [31:0]      rsp_q;
    logic             can_issue;

    assign can_issue = !sticky_busy && !sticky_failed &&
                       (upd_op != DMI_NOP) && (upd_op != DMI_RSVD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FSM_IDLE;
            sticky_busy   <= 1'b0;
            sticky_failed <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            op_q          <= '0;
            rsp_q         <= '0;
        end else if (hard_reset) begin
            // Abort whatever is in flight; a late response finds us IDLE and is dropped.
            state         <= FSM_IDLE;
            sticky_busy   <= 1'b0;
            sticky_failed <= 1'b0;
        end else begin
            case (state)
                FSM_IDLE: begin
                    if (dmi_update && can_issue) begin
                        addr_q <= upd_addr;
                        data_q <= upd_data;
                        op_q   <= upd_op;
                        state  <= FSM_REQ;
                    end
                end
                FSM_REQ: begin
                    if (dmi.req_ready) begin
                        state <= FSM_WAIT;
                    end
                end
                FSM_WAIT: begin
                    if (dmi.rsp_valid) begin
                        if (op_q == DMI_READ) begin
                            rsp_q <= dmi.rsp_data;
                        end
                        if (dmi.rsp_op == STAT_FAILED) begin
                            sticky_failed <= 1'b1;
                        end
                        state <= FSM_IDLE;
                    end
                end
                default: state <= FSM_IDLE;
            endcase

            if (dmi_update && (state != FSM_IDLE)) begin
                sticky_busy <= 1'b1;
            end
            // Placed last so a dmireset wins over a failure flagged on the same edge.
            if (clear_sticky) begin
                sticky_busy   <= 1'b0;
                sticky_failed <= 1'b0;
            end
        end
    end

    assign dmi.req_valid = (state == FSM_REQ);
    assign dmi.req_addr  = addr_q;
    assign dmi.req_data  = data_q;
    assign dmi.req_op    = op_q;
    assign last_addr     = addr_q;
    assign rsp_data      = rsp_q;
    assign status        = ((state != FSM_IDLE) || sticky_busy) ? STAT_BUSY :
                           sticky_failed ? STAT_FAILED : STAT_OK;

endmodule

// File: rtl/tap_dtm_sequencer.sv
// JTAG debug transport behind the TAP controller: instruction register,
// DR chain selection and TDO driver, with DMI updates handed to the FSM.
module tap_dtm_sequencer
    import tap_dtm_sequencer_pkg::*;
#(
    parameter int          IR_W   = 5,
    parameter int          ABITS  = 7,
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic tck_i,
    input  logic trst_i,
    input  logic tdi_i,
    input  logic captureIR_i,
    input  logic shiftIR_i,
    input  logic updateIR_i,
    input  logic captureDR_i,
    input  logic shiftDR_i,
    input  logic updateDR_i,
    output logic tdo_o,
    output logic tdo_en_o,
    tap_dtm_sequencer_if.master dmi
);

    localparam int DMI_W = ABITS + 34;

    logic [IR_W-1:0]  ir_sr;
    logic [IR_W-1:0]  ir_q;
    logic [31:0]      idcode_sr;
    logic [31:0]      dtmcs_sr;
    logic [DMI_W-1:0] dmi_sr;
    logic             bypass_sr;
    logic [1:0]       chain;
    logic             dr_lsb;
    logic [ABITS-1:0] last_addr;
    logic [31:0]      rsp_data;
    logic [1:0]       status;
    logic [31:0]      dtmcs_capture;
    logic             dmi_update;
    logic             dtmcs_update;
    logic             clear_sticky;
    logic             hard_reset;

    always_comb begin
        chain = CH_BYPASS;
        case (ir_q)
            IR_W'(IR_IDCODE): chain = CH_IDCODE;
            IR_W'(IR_DTMCS):  chain = CH_DTMCS;
            IR_W'(IR_DMI):    chain = CH_DMI;
            IR_W'(IR_BYPASS): chain = CH_BYPASS;
            default:          chain = CH_BYPASS;
        endcase
    end

    assign dtmcs_capture = {14'b0, 2'b0, 1'b0, 3'd0, status, 6'(ABITS), 4'd1};

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_sr <= '0;
            ir_q  <= IR_W'(IR_IDCODE);
        end else begin
            if (captureIR_i) begin
                ir_sr <= IR_W'(1);
            end else if (shiftIR_i) begin
                ir_sr <= {tdi_i, ir_sr[IR_W-1:1]};
            end
            if (updateIR_i) begin
                ir_q <= ir_sr;
            end
        end
    end

    // Only the chain selected by ir_q captures or shifts; the others keep their contents.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            idcode_sr <= '0;
            dtmcs_sr  <= '0;
            dmi_sr    <= '0;
            bypass_sr <= 1'b0;
        end else if (captureDR_i) begin
            case (chain)
                CH_IDCODE: idcode_sr <= IDCODE;
                CH_DTMCS:  dtmcs_sr  <= dtmcs_capture;
                CH_DMI:    dmi_sr    <= {last_addr, rsp_data, status};
                default:   bypass_sr <= 1'b0;
            endcase
        end else if (shiftDR_i) begin
            case (chain)
                CH_IDCODE: idcode_sr <= {tdi_i, idcode_sr[31:1]};
                CH_DTMCS:  dtmcs_sr  <= {tdi_i, dtmcs_sr[31:1]};
                CH_DMI:    dmi_sr    <= {tdi_i, dmi_sr[DMI_W-1:1]};
                default:   bypass_sr <= tdi_i;
            endcase
        end
    end

    always_comb begin
        case (chain)
            CH_IDCODE: dr_lsb = idcode_sr[0];
            CH_DTMCS:  dr_lsb = dtmcs_sr[0];
            CH_DMI:    dr_lsb = dmi_sr[0];
            default:   dr_lsb = bypass_sr;
        endcase
    end

    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_o    <= 1'b0;
            tdo_en_o <= 1'b0;
        end else begin
            tdo_en_o <= shiftIR_i | shiftDR_i;
            if (shiftIR_i) begin
                tdo_o <= ir_sr[0];
            end else if (shiftDR_i) begin
                tdo_o <= dr_lsb;
            end else begin
                tdo_o <= 1'b0;
            end
        end
    end

    assign dmi_update   = updateDR_i && (chain == CH_DMI);
    assign dtmcs_update = updateDR_i && (chain == CH_DTMCS);
    assign hard_reset   = dtmcs_update && dtmcs_sr[DTMCS_HARDRESET_BIT];
    assign clear_sticky = dtmcs_update &&
                          (dtmcs_sr[DTMCS_DMIRESET_BIT] || dtmcs_sr[DTMCS_HARDRESET_BIT]);

    tap_dtm_sequencer_dmi_fsm #(
        .ABITS (ABITS)
    ) u_dmi_fsm (
        .clk          (tck_i),
        .rst          (trst_i),
        .dmi_update   (dmi_update),
        .upd_addr     (dmi_sr[DMI_W-1:34]),
        .upd_data     (dmi_sr[33:2]),
        .upd_op       (dmi_sr[1:0]),
        .clear_sticky (clear_sticky),
        .hard_reset   (hard_reset),
        .dmi          (dmi),
        .last_addr    (last_addr),
        .rsp_data     (rsp_data),
        .status       (status)
    );

endmodule

// File: tb/tb_tap_dtm_sequencer.sv
// Directed bench for tap_dtm_sequencer: a transaction-level model checked every
// cycle, plus hand-computed scan results for IDCODE, BYPASS, DTMCS and DMI.
module tb_tap_dtm_sequencer;

    localparam int AB      = 7;
    localparam int DMI_LEN = AB + 34;

    logic tck = 1'b0;
    logic trst = 1'b1;
    logic tdi = 1'b0;
    logic cap_ir = 1'b0, sh_ir = 1'b0, up_ir = 1'b0;
    logic cap_dr = 1'b0, sh_dr = 1'b0, up_dr = 1'b0;
    logic tdo, tdo_en;

    int tests_run = 0;
    int tests_failed = 0;

    tap_dtm_sequencer_if #(.ABITS(AB)) dmi_if ();

    tap_dtm_sequencer #(
        .IR_W   (5),
        .ABITS  (AB),
        .IDCODE (32'h1000_0001)
    ) dut (
        .tck_i       (tck),
        .trst_i      (trst),
        .tdi_i       (tdi),
        .captureIR_i (cap_ir),
        .shiftIR_i   (sh_ir),
        .updateIR_i  (up_ir),
        .captureDR_i (cap_dr),
        .shiftDR_i   (sh_dr),
        .updateDR_i  (up_dr),
        .tdo_o       (tdo),
        .tdo_en_o    (tdo_en),
        .dmi         (dmi_if)
    );

    always #5 tck = ~tck;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state: one outstanding transaction at most, tracked as pending/accepted.
    logic [4:0]    m_ir = 5'h01;
    logic [4:0]    m_ir_sr = 5'h00;
    logic [63:0]   m_chain [4];
    logic [AB-1:0] m_last_addr = '0;
    logic [31:0]   m_rsp_data = '0;
    logic [AB-1:0] m_addr = '0;
    logic [31:0]   m_data = '0;
    logic [1:0]    m_op = '0;
    bit            m_sticky_busy = 0, m_sticky_failed = 0, m_pending = 0, m_accepted = 0;
    bit            m_was_pending = 0;
    logic [1:0]    m_st = '0;
    int            m_c = 0;
    logic [63:0]   m_v = '0;
    logic          exp_tdo = 1'b0, exp_tdo_en = 1'b0;
    bit            model_live = 0;

    function automatic int chain_of(input logic [4:0] ir);
        case (ir)
            5'h01:   return 0;
            5'h10:   return 1;
            5'h11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            0, 1:    return 32;
            2:       return DMI_LEN;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    always @(posedge tck) begin
        if (trst) begin
            m_ir = 5'h01; m_ir_sr = '0;
            for (int i = 0; i < 4; i++) m_chain[i] = '0;
            m_last_addr = '0; m_rsp_data = '0;
            m_addr = '0; m_data = '0; m_op = '0;
            m_sticky_busy = 0; m_sticky_failed = 0; m_pending = 0; m_accepted = 0;
            exp_tdo = 1'b0; exp_tdo_en = 1'b0;
            model_live = 1;
        end else begin
            m_was_pending = m_pending;
            m_st = (m_pending || m_sticky_busy) ? 2'd3 : (m_sticky_failed ? 2'd2 : 2'd0);
            m_c = chain_of(m_ir);
            if (m_pending && !m_accepted && dmi_if.req_ready) begin
                m_accepted = 1;
            end else if (m_pending && m_accepted && dmi_if.rsp_valid) begin
                if (m_op == 2'd1) m_rsp_data = dmi_if.rsp_data;
                if (dmi_if.rsp_op == 2'd2) m_sticky_failed = 1;
                m_pending = 0;
                m_accepted = 0;
            end
            if (cap_ir) m_ir_sr = 5'b00001;
            else if (sh_ir) m_ir_sr = {tdi, m_ir_sr[4:1]};
            if (up_ir) m_ir = m_ir_sr;
            if (cap_dr) begin
                case (m_c)
                    0:       m_chain[0] = 64'h1000_0001;
                    1:       m_chain[1] = 64'(m_st) * 1024 + 64'(AB) * 16 + 64'd1;
                    2:       m_chain[2] = (64'(m_last_addr) << 34) | (64'(m_rsp_data) << 2) | 64'(m_st);
                    default: m_chain[3] = '0;
                endcase
            end else if (sh_dr) begin
                m_chain[m_c] = (m_chain[m_c] >> 1) | (64'(tdi) << (len_of(m_c) - 1));
            end
            if (up_dr && m_c == 1) begin
                m_v = m_chain[1];
                if (m_v[16] || m_v[17]) begin
                    m_sticky_busy = 0;
                    m_sticky_failed = 0;
                end
                if (m_v[17]) begin
                    m_pending = 0;
                    m_accepted = 0;
                end
            end else if (up_dr && m_c == 2) begin
                m_v = m_chain[2];
                if (m_was_pending) begin
                    m_sticky_busy = 1;
                end else if (!m_sticky_busy && !m_sticky_failed && m_v[1:0] != 2'd0 && m_v[1:0] != 2'd3) begin
                    m_pending = 1;
                    m_accepted = 0;
                    m_addr = m_v[DMI_LEN-1:34];
                    m_data = m_v[33:2];
                    m_op = m_v[1:0];
                    m_last_addr = m_v[DMI_LEN-1:34];
                end
            end
        end
    end

    always @(negedge tck) begin
        if (trst) begin
            exp_tdo = 1'b0;
            exp_tdo_en = 1'b0;
        end else begin
            exp_tdo_en = sh_ir | sh_dr;
            if (sh_ir) exp_tdo = m_ir_sr[0];
            else if (sh_dr) exp_tdo = m_chain[chain_of(m_ir)][0];
            else exp_tdo = 1'b0;
        end
    end

    always @(posedge tck) begin
        #1;
        if (model_live) begin
            check_output("req_valid", dmi_if.req_valid, m_pending && !m_accepted);
            if (m_pending && !m_accepted) begin
                check_output("req_addr", dmi_if.req_addr, m_addr);
                check_output("req_data", dmi_if.req_data, m_data);
                check_output("req_op", dmi_if.req_op, m_op);
            end
            check_output("tdo", tdo, exp_tdo);
            check_output("tdo_en", tdo_en, exp_tdo_en);
        end
    end

    task automatic tick();
        @(posedge tck);
        #2;
    endtask

    task automatic ir_scan(input logic [4:0] ir, output logic [4:0] out);
        out = '0;
        cap_ir = 1'b1; tick(); cap_ir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sh_ir = 1'b1; tdi = ir[i]; tick(); out[i] = tdo;
        end
        sh_ir = 1'b0; tdi = 1'b0;
        up_ir = 1'b1; tick(); up_ir = 1'b0;
    endtask

    task automatic dr_scan(input int len, input logic [63:0] din, input bit do_update, output logic [63:0] dout);
        dout = '0;
        cap_dr = 1'b1; tick(); cap_dr = 1'b0;
        for (int i = 0; i < len; i++) begin
            sh_dr = 1'b1; tdi = din[i]; tick(); dout[i] = tdo;
        end
        sh_dr = 1'b0; tdi = 1'b0;
        if (do_update) begin
            up_dr = 1'b1; tick(); up_dr = 1'b0;
        end
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] op);
        dmi_if.rsp_valid = 1'b1; dmi_if.rsp_data = data; dmi_if.rsp_op = op;
        tick();
        dmi_if.rsp_valid = 1'b0; dmi_if.rsp_data = '0; dmi_if.rsp_op = '0;
    endtask

    task automatic accept();
        dmi_if.req_ready = 1'b1; tick(); dmi_if.req_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  ir_out;
        logic [63:0] out;
        int          cnt;

        dmi_if.req_ready = 1'b0;
        dmi_if.rsp_valid = 1'b0;
        dmi_if.rsp_data  = '0;
        dmi_if.rsp_op    = '0;
        repeat (3) @(posedge tck);
        #2;
        check_output("reset_valid", dmi_if.req_valid, 1'b0);
        check_output("reset_addr", dmi_if.req_addr, 7'h00);
        check_output("reset_op", dmi_if.req_op, 2'd0);
        check_output("reset_tdo_en", tdo_en, 1'b0);
        trst = 1'b0;
        tick();

        // IR resets to IDCODE, so a bare DR scan returns the ID.
        dr_scan(32, 64'h0, 0, out);
        check_output("idcode_after_reset", out[31:0], 32'h1000_0001);
        ir_scan(5'h01, ir_out);
        check_output("ir_capture", ir_out, 5'b00001);
        dr_scan(32, 64'h0, 1, out);
        check_output("idcode_scan", out[31:0], 32'h1000_0001);

        ir_scan(5'h1F, ir_out);
        dr_scan(4, 64'b0101, 1, out);
        check_output("bypass_1f", out[3:0], 4'b1010);
        ir_scan(5'h07, ir_out);
        dr_scan(4, 64'b0101, 1, out);
        check_output("bypass_07", out[3:0], 4'b1010);

        // DMI write, debug module ready after three cycles.
        ir_scan(5'h11, ir_out);
        dr_scan(DMI_LEN, dmi_word(7'h10, 32'hDEAD_BEEF, 2'd2), 1, out);
        check_output("first_dmi_capture", out, dmi_word(7'h00, 32'h0, 2'd0));
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (dmi_if.req_valid === 1'b1 && dmi_if.req_addr === 7'h10 &&
                dmi_if.req_data === 32'hDEAD_BEEF && dmi_if.req_op === 2'd2) cnt++;
            if (k == 2) dmi_if.req_ready = 1'b1;
            tick();
        end
        dmi_if.req_ready = 1'b0;
        check_output("write_valid_cycles", cnt, 3);
        check_output("write_valid_drop", dmi_if.req_valid, 1'b0);
        tick();
        respond(32'hFFFF_0000, 2'd0);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("write_done_capture", out, dmi_word(7'h10, 32'h0, 2'd0));

        // DMI read returns data on the next capture.
        dr_scan(DMI_LEN, dmi_word(7'h04, 32'h0, 2'd1), 1, out);
        check_output("read_valid", dmi_if.req_valid, 1'b1);
        check_output("read_op", dmi_if.req_op, 2'd1);
        accept();
        tick();
        respond(32'h1234_5678, 2'd0);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("read_capture", out, dmi_word(7'h04, 32'h1234_5678, 2'd0));

        // Update while waiting for a response sets sticky busy.
        dr_scan(DMI_LEN, dmi_word(7'h08, 32'h55, 2'd2), 1, out);
        accept();
        dr_scan(DMI_LEN, dmi_word(7'h09, 32'h66, 2'd2), 1, out);
        check_output("busy_capture_wait", out, dmi_word(7'h08, 32'h1234_5678, 2'd3));
        check_output("busy_no_new_valid", dmi_if.req_valid, 1'b0);
        respond(32'h0, 2'd0);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("busy_sticky_op", out[1:0], 2'd3);
        ir_scan(5'h10, ir_out);
        dr_scan(32, 64'h1_0000, 1, out);
        check_output("dtmcs_busy", out[31:0], 32'h0000_0C71);
        ir_scan(5'h11, ir_out);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("dmireset_capture", out, dmi_word(7'h08, 32'h1234_5678, 2'd0));

        // Failed response blocks later requests until dmireset.
        dr_scan(DMI_LEN, dmi_word(7'h0A, 32'h1, 2'd2), 1, out);
        accept();
        respond(32'h0, 2'd2);
        dr_scan(DMI_LEN, dmi_word(7'h0B, 32'h2, 2'd2), 1, out);
        check_output("failed_capture", out, dmi_word(7'h0A, 32'h1234_5678, 2'd2));
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (dmi_if.req_valid !== 1'b0) cnt++;
            tick();
        end
        check_output("failed_blocks_request", cnt, 0);
        ir_scan(5'h10, ir_out);
        dr_scan(32, 64'h1_0000, 1, out);
        check_output("dtmcs_failed", out[31:0], 32'h0000_0871);

        // dmihardreset while the request is still waiting for ready.
        ir_scan(5'h11, ir_out);
        dr_scan(DMI_LEN, dmi_word(7'h0C, 32'h7, 2'd2), 1, out);
        check_output("hard_req_valid", dmi_if.req_valid, 1'b1);
        ir_scan(5'h10, ir_out);
        check_output("hard_valid_held", dmi_if.req_valid, 1'b1);
        dr_scan(32, 64'h2_0000, 1, out);
        check_output("dtmcs_during_req", out[31:0], 32'h0000_0C71);
        check_output("hard_valid_low", dmi_if.req_valid, 1'b0);
        accept();
        respond(32'h0000_0BAD, 2'd2);
        ir_scan(5'h11, ir_out);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("hard_capture", out, dmi_word(7'h0C, 32'h1234_5678, 2'd0));

        // trst in the middle of a request clears everything immediately.
        dr_scan(DMI_LEN, dmi_word(7'h0D, 32'hAA, 2'd2), 1, out);
        check_output("trst_req_valid", dmi_if.req_valid, 1'b1);
        trst = 1'b1;
        #1;
        check_output("trst_valid", dmi_if.req_valid, 1'b0);
        check_output("trst_addr", dmi_if.req_addr, 7'h00);
        check_output("trst_data", dmi_if.req_data, 32'h0);
        check_output("trst_op", dmi_if.req_op, 2'd0);
        check_output("trst_tdo", tdo, 1'b0);
        tick();
        trst = 1'b0;
        tick();
        dr_scan(32, 64'h0, 0, out);
        check_output("idcode_after_trst", out[31:0], 32'h1000_0001);
        ir_scan(5'h11, ir_out);
        dr_scan(DMI_LEN, dmi_word(7'h00, 32'h0, 2'd0), 1, out);
        check_output("dmi_after_trst", out, dmi_word(7'h00, 32'h0, 2'd0));

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
